// File: rtl/alu_pkg.sv
// alu_pkg: shared types and decode helpers for alu_core.
//   state_e      operand-wait FSM states
//   arith_cmd_e  command codes when mode=1
//   logic_cmd_e  command codes when mode=0
//   ROT_BITS     rotate-amount width for the default operand width
//   op_mask()    operands a {mode, cmd} pair needs (bit0=A, bit1=B, 00=invalid)
// Optional feature macro: ALU_MUL_EN (multiply commands decode as valid only when defined).
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 8;
  localparam int CMD_W          = 4;
  localparam int ROT_BITS       = $clog2(ALU_DATA_WIDTH);

  localparam logic [1:0] NEED_NONE = 2'b00;
  localparam logic [1:0] NEED_A    = 2'b01;
  localparam logic [1:0] NEED_B    = 2'b10;
  localparam logic [1:0] NEED_AB   = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT_OP, MUL} state_e;

  typedef enum logic [CMD_W-1:0] {
    CMD_ADD      = 4'd0,
    CMD_SUB      = 4'd1,
    CMD_ADD_CIN  = 4'd2,
    CMD_SUB_CIN  = 4'd3,
    CMD_INC_A    = 4'd4,
    CMD_DEC_A    = 4'd5,
    CMD_INC_B    = 4'd6,
    CMD_DEC_B    = 4'd7,
    CMD_CMP      = 4'd8,
    CMD_INC_MUL  = 4'd9,
    CMD_SHL1_MUL = 4'd10
  } arith_cmd_e;

  typedef enum logic [CMD_W-1:0] {
    CMD_AND     = 4'd0,
    CMD_NAND    = 4'd1,
    CMD_OR      = 4'd2,
    CMD_NOR     = 4'd3,
    CMD_XOR     = 4'd4,
    CMD_XNOR    = 4'd5,
    CMD_NOT_A   = 4'd6,
    CMD_NOT_B   = 4'd7,
    CMD_SHR1_A  = 4'd8,
    CMD_SHL1_A  = 4'd9,
    CMD_SHR1_B  = 4'd10,
    CMD_SHL1_B  = 4'd11,
    CMD_ROL_A_B = 4'd12,
    CMD_ROR_A_B = 4'd13
  } logic_cmd_e;

  function automatic logic [1:0] op_mask(input logic mode, input logic [CMD_W-1:0] code);
    logic [1:0] m;
    m = NEED_NONE;
    if (mode) begin
      case (code)
        CMD_ADD, CMD_SUB, CMD_ADD_CIN, CMD_SUB_CIN, CMD_CMP: m = NEED_AB;
`ifdef ALU_MUL_EN
        CMD_INC_MUL, CMD_SHL1_MUL: m = NEED_AB;
`endif
        CMD_INC_A, CMD_DEC_A: m = NEED_A;
        CMD_INC_B, CMD_DEC_B: m = NEED_B;
        default: m = NEED_NONE;
      endcase
    end else begin
      case (code)
        CMD_AND, CMD_NAND, CMD_OR, CMD_NOR, CMD_XOR, CMD_XNOR,
        CMD_ROL_A_B, CMD_ROR_A_B: m = NEED_AB;
        CMD_NOT_A, CMD_SHR1_A, CMD_SHL1_A: m = NEED_A;
        CMD_NOT_B, CMD_SHR1_B, CMD_SHL1_B: m = NEED_B;
        default: m = NEED_NONE;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_comb_unit.sv
// alu_comb_unit: purely combinational evaluation of one ALU command.
//   mode, cin, cmd, a, b  -> res, cout, oflow, g, l, e, err
//   need    operands the command requires (00 = invalid command)
//   is_mul  command goes through the two-cycle multiply path
// Optional feature macro: ALU_MUL_EN (adds INC_MUL / SHL1_MUL product logic).
module alu_comb_unit import alu_pkg::*; #(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int CMD_WIDTH  = CMD_W,
  parameter int ROT_W      = ROT_BITS
) (
  input  logic                  mode,
  input  logic                  cin,
  input  logic [CMD_WIDTH-1:0]  cmd,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH:0]   res,
  output logic                  cout,
  output logic                  oflow,
  output logic                  g,
  output logic                  l,
  output logic                  e,
  output logic                  err,
  output logic [1:0]            need,
  output logic                  is_mul
);

  localparam int CW = (CMD_WIDTH > CMD_W) ? CMD_WIDTH : CMD_W;

  logic [CW-1:0]           cmd_ext;
  logic [CMD_W-1:0]        code;
  logic                    code_ok;
  logic [DATA_WIDTH:0]     ax, bx, cx, one;
  logic [DATA_WIDTH-1:0]   lres;
  logic [ROT_W-1:0]        amt;
  logic                    rot_hi;
  logic [2*DATA_WIDTH-1:0] rol_w, ror_w;

  // Command bits above the 4-bit code make the command invalid.
  assign cmd_ext = CW'(cmd);
  assign code    = cmd_ext[CMD_W-1:0];
  assign code_ok = (cmd_ext >> CMD_W) == '0;
  assign need    = code_ok ? op_mask(mode, code) : NEED_NONE;

  assign ax  = {1'b0, a};
  assign bx  = {1'b0, b};
  assign cx  = (DATA_WIDTH+1)'(cin);
  assign one = (DATA_WIDTH+1)'(1);

  // Upper half of {a,a}<<n is a rotated left; lower half of {a,a}>>n is a rotated right.
  assign amt    = b[ROT_W-1:0];
  assign rot_hi = |(b >> ROT_W);
  assign rol_w  = {a, a} << amt;
  assign ror_w  = {a, a} >> amt;

`ifdef ALU_MUL_EN
  localparam int PW = 2*DATA_WIDTH + 2;
  logic [PW-1:0] prod_inc, prod_shl;
  assign prod_inc = (PW'(a) + PW'(1)) * (PW'(b) + PW'(1));
  assign prod_shl = (PW'(a) << 1) * PW'(b);
  assign is_mul   = code_ok && mode && (code == CMD_INC_MUL || code == CMD_SHL1_MUL);
`else
  assign is_mul   = 1'b0;
`endif

  always_comb begin
    res   = '0;
    cout  = 1'b0;
    oflow = 1'b0;
    g     = 1'b0;
    l     = 1'b0;
    e     = 1'b0;
    err   = 1'b0;
    lres  = '0;
    if (need == NEED_NONE) begin
      err = 1'b1;
    end else if (mode) begin
      case (code)
        CMD_ADD:     begin res = ax + bx;      cout = res[DATA_WIDTH]; end
        CMD_ADD_CIN: begin res = ax + bx + cx; cout = res[DATA_WIDTH]; end
        CMD_SUB:     begin res = ax - bx;      oflow = ax < bx; end
        CMD_SUB_CIN: begin res = ax - bx - cx; oflow = ax < (bx + cx); end
        CMD_INC_A:   res = ax + one;
        CMD_DEC_A:   begin res = ax - one; oflow = (a == '0); end
        CMD_INC_B:   res = bx + one;
        CMD_DEC_B:   begin res = bx - one; oflow = (b == '0); end
        CMD_CMP:     begin g = a > b; l = a < b; e = a == b; end
`ifdef ALU_MUL_EN
        CMD_INC_MUL:  begin res = prod_inc[DATA_WIDTH:0]; oflow = |prod_inc[PW-1:DATA_WIDTH+1]; end
        CMD_SHL1_MUL: begin res = prod_shl[DATA_WIDTH:0]; oflow = |prod_shl[PW-1:DATA_WIDTH+1]; end
`endif
        default: err = 1'b1;
      endcase
    end else begin
      case (code)
        CMD_AND:     lres = a & b;
        CMD_NAND:    lres = ~(a & b);
        CMD_OR:      lres = a | b;
        CMD_NOR:     lres = ~(a | b);
        CMD_XOR:     lres = a ^ b;
        CMD_XNOR:    lres = ~(a ^ b);
        CMD_NOT_A:   lres = ~a;
        CMD_NOT_B:   lres = ~b;
        CMD_SHR1_A:  lres = a >> 1;
        CMD_SHL1_A:  lres = a << 1;
        CMD_SHR1_B:  lres = b >> 1;
        CMD_SHL1_B:  lres = b << 1;
        CMD_ROL_A_B: begin lres = rol_w[2*DATA_WIDTH-1:DATA_WIDTH]; err = rot_hi; end
        CMD_ROR_A_B: begin lres = ror_w[DATA_WIDTH-1:0];            err = rot_hi; end
        default:     err = 1'b1;
      endcase
      res = {1'b0, lres};
    end
  end

endmodule

// File: rtl/alu_core.sv
// alu_core: registered ALU with operand-wait FSM, timeout and optional multiply path.
//   clk, rst (async, active-high), ce (0 freezes everything)
//   mode, cin, cmd, inp_valid[1:0] (bit0=opa, bit1=opb), opa, opb
//   res[DATA_WIDTH:0], cout, oflow, g, l, e, err -- registered, held between writes
// Optional feature macro: ALU_MUL_EN (INC_MUL / SHL1_MUL via the MUL state).
//
// state   | meaning
// IDLE    | accept a new command; results with both operands present written next edge
// WAIT_OP | one operand latched, waiting up to WAIT_CYCLES ce cycles for the other
// MUL     | operands complete, product written at the following edge
module alu_core import alu_pkg::*; #(
  parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
  parameter int CMD_WIDTH   = CMD_W,
  parameter int WAIT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  mode,
  input  logic                  cin,
  input  logic [1:0]            inp_valid,
  input  logic [CMD_WIDTH-1:0]  cmd,
  input  logic [DATA_WIDTH-1:0] opa,
  input  logic [DATA_WIDTH-1:0] opb,
  output logic [DATA_WIDTH:0]   res,
  output logic                  oflow,
  output logic                  cout,
  output logic                  g,
  output logic                  l,
  output logic                  e,
  output logic                  err
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  state_e                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [1:0]            have, have_n;
  logic [DATA_WIDTH-1:0] lat_a, lat_a_n, lat_b, lat_b_n;
  logic [CMD_WIDTH-1:0]  lat_cmd, lat_cmd_n;
  logic                  lat_mode, lat_mode_n, lat_cin, lat_cin_n;
  logic                  wr_res, wr_err;

  logic                  in_idle;
  logic [DATA_WIDTH-1:0] a_sel, b_sel;
  logic [CMD_WIDTH-1:0]  cmd_sel;
  logic                  mode_sel, cin_sel;
  logic [DATA_WIDTH:0]   c_res;
  logic                  c_cout, c_oflow, c_g, c_l, c_e, c_err, is_mul;
  logic [1:0]            need;

  // Outside IDLE the command is the latched one; a missing operand comes from the live bus.
  assign in_idle  = (state == IDLE);
  assign a_sel    = (in_idle || !have[0]) ? opa : lat_a;
  assign b_sel    = (in_idle || !have[1]) ? opb : lat_b;
  assign cmd_sel  = in_idle ? cmd  : lat_cmd;
  assign mode_sel = in_idle ? mode : lat_mode;
  assign cin_sel  = in_idle ? cin  : lat_cin;

  alu_comb_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .CMD_WIDTH  (CMD_WIDTH),
    .ROT_W      ($clog2(DATA_WIDTH))
  ) u_comb (
    .mode   (mode_sel),
    .cin    (cin_sel),
    .cmd    (cmd_sel),
    .a      (a_sel),
    .b      (b_sel),
    .res    (c_res),
    .cout   (c_cout),
    .oflow  (c_oflow),
    .g      (c_g),
    .l      (c_l),
    .e      (c_e),
    .err    (c_err),
    .need   (need),
    .is_mul (is_mul)
  );

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    have_n     = have;
    lat_a_n    = lat_a;
    lat_b_n    = lat_b;
    lat_cmd_n  = lat_cmd;
    lat_mode_n = lat_mode;
    lat_cin_n  = lat_cin;
    wr_res     = 1'b0;
    wr_err     = 1'b0;
    if (ce) begin
      case (state)
        IDLE: begin
          if (inp_valid == 2'b00) begin
            wr_err = 1'b1;
          end else if (need != NEED_AB) begin
            // Invalid commands (need=00) pass here too; the comb unit flags them.
            if ((inp_valid & need) == need) wr_res = 1'b1;
            else                            wr_err = 1'b1;
          end else if (inp_valid == 2'b11 && !is_mul) begin
            wr_res = 1'b1;
          end else begin
            if (inp_valid[0]) lat_a_n = opa;
            if (inp_valid[1]) lat_b_n = opb;
            lat_cmd_n  = cmd;
            lat_mode_n = mode;
            lat_cin_n  = cin;
            have_n     = inp_valid;
            cnt_n      = '0;
            state_n    = (inp_valid == 2'b11) ? MUL : WAIT_OP;
          end
        end
        WAIT_OP: begin
          if ((inp_valid & ~have) != 2'b00) begin
            lat_a_n = a_sel;
            lat_b_n = b_sel;
            have_n  = 2'b11;
            if (is_mul) begin
              state_n = MUL;
            end else begin
              wr_res  = 1'b1;
              state_n = IDLE;
            end
          end else if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
            wr_err  = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          wr_res  = 1'b1;
          state_n = IDLE;
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      have     <= '0;
      lat_a    <= '0;
      lat_b    <= '0;
      lat_cmd  <= '0;
      lat_mode <= 1'b0;
      lat_cin  <= 1'b0;
      res      <= '0;
      cout     <= 1'b0;
      oflow    <= 1'b0;
      g        <= 1'b0;
      l        <= 1'b0;
      e        <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      have     <= have_n;
      lat_a    <= lat_a_n;
      lat_b    <= lat_b_n;
      lat_cmd  <= lat_cmd_n;
      lat_mode <= lat_mode_n;
      lat_cin  <= lat_cin_n;
      if (wr_err) begin
        res   <= '0;
        cout  <= 1'b0;
        oflow <= 1'b0;
        g     <= 1'b0;
        l     <= 1'b0;
        e     <= 1'b0;
        err   <= 1'b1;
      end else if (wr_res) begin
        res   <= c_res;
        cout  <= c_cout;
        oflow <= c_oflow;
        g     <= c_g;
        l     <= c_l;
        e     <= c_e;
        err   <= c_err;
      end
    end
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Synthesizable ALU datapath that the UVM ALU bench drives and monitors.
- Accepts operands, command and mode with per-operand valid qualifiers.
- Returns a registered result plus carry, overflow, compare and error flags.
- Includes an operand-wait FSM with timeout and an optional 2-cycle multiply path.

Parameters:
- DATA_WIDTH, 8, operand width.
- CMD_WIDTH, 4, command field width.
- WAIT_CYCLES, 16, ce-qualified cycles allowed for the missing operand.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- ce  input  1  clock enable; 0 freezes FSM, counters and outputs
- mode  input  1  1=arithmetic, 0=logical
- cin  input  1  carry-in for ADD_CIN/SUB_CIN
- inp_valid  input  2  bit0=opa valid, bit1=opb valid
- cmd  input  CMD_WIDTH  operation code
- opa  input  DATA_WIDTH  operand A
- opb  input  DATA_WIDTH  operand B
- res  output  DATA_WIDTH+1  result
- oflow  output  1  overflow/borrow
- cout  output  1  carry-out
- g, l, e  output  1 each  A>B, A<B, A==B (CMP only)
- err  output  1  invalid command, operand, timeout or rotate amount

Behaviour:
- Reset: clk is the clock; rst is asynchronous, active-high.
  - All outputs reset to 0; FSM to IDLE; wait counter 0; latched operands 0.
  - Reset mid-operation aborts the operation; no result is produced.
- Outputs are registered and hold their value until the next result is written.
  - Every result write clears any flag that the command does not define.
- Arithmetic commands (mode=1):
  - Two-operand: 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN, 8 CMP, 9 INC_MUL (a+1)*(b+1), 10 SHL1_MUL (a<<1)*b.
  - A-only: 4 INC_A, 5 DEC_A. B-only: 6 INC_B, 7 DEC_B.
- Logical commands (mode=0):
  - Two-operand: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 12 ROL_A_B, 13 ROR_A_B.
  - A-only: 6 NOT_A, 8 SHR1_A, 9 SHL1_A. B-only: 7 NOT_B, 10 SHR1_B, 11 SHL1_B.
  - Results are zero-extended, so res[DATA_WIDTH]=0.
- Unlisted cmd: err=1, res=0, latency 1.
- Arithmetic width rules (DATA_WIDTH+1 bits):
  - ADD/ADD_CIN: cout=res[DATA_WIDTH].
  - SUB/SUB_CIN: oflow=1 when opa < opb+cin; res is the (DATA_WIDTH+1)-bit two's-complement difference.
  - INC of all-ones gives 1<<DATA_WIDTH. DEC of 0 gives all-ones, with oflow=1.
  - CMP: res=0; exactly one of g/l/e is 1.
- Rotates:
  - Amount is opb[$clog2(DATA_WIDTH)-1:0].
  - If any higher opb bit is set, err=1 but the rotated result is still written.
- FSM states: IDLE, WAIT_OP, MUL.
  - IDLE, ce=1, inp_valid=00: err=1, res=0.
  - IDLE, single-operand cmd without its valid bit: err=1.
  - IDLE, two-operand non-mul cmd with 11: result at the next edge (latency 1).
  - IDLE, two-operand cmd with 01 or 10: latch the given operand plus cmd/mode/cin; go to WAIT_OP; counter=0; outputs hold.
  - WAIT_OP: each ce cycle samples only the missing operand's bit. When set, latch that operand and write the result at this edge (or go to MUL for multiply); return to IDLE.
  - WAIT_OP: cmd/mode changes are ignored.
  - WAIT_OP timeout: after WAIT_CYCLES cycles without the operand, err=1, res=0, other flags 0, return to IDLE.
  - MUL: inputs are ignored. The result is written at the 2nd edge after operand completion, then return to IDLE.
  - Product is truncated to DATA_WIDTH+1 bits; oflow=1 if any truncated bit is nonzero.
- ce=0 in any state: no state change, counter frozen, outputs held.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: INC_MUL and SHL1_MUL are implemented through the MUL state with latency 2.
- Undefined: arithmetic cmds 9 and 10 decode as invalid (err=1, res=0, latency 1), and the MUL state and multiplier are removed.

Decomposition:
- Package alu_pkg holds:
  - state_e enum {IDLE, WAIT_OP, MUL}.
  - arith_cmd_e and logic_cmd_e enums with the codes above.
  - A constant ROT_BITS=$clog2(DATA_WIDTH).
  - A function giving the required operand mask per {mode, cmd}.
- One sub-module, alu_comb_unit: purely combinational op evaluation from operands, cmd, mode and cin to res and flags. alu_core owns the FSM, counter and output registers.

Test Plan:
- ADD, opa=8'hFF, opb=8'h01, inp_valid=11 -> next edge res=9'h100, cout=1, err=0.
- SUB, opa=8'h05, opb=8'h07 -> res=9'h1FE, oflow=1. CMP, opa=8'h10, opb=8'h20 -> l=1, g=0, e=0, res=0.
- ADD with inp_valid=01, opa=3; two idle cycles; then inp_valid=10, opb=4 -> res=7 at that edge, err=0.
- inp_valid=01 on AND, then 16 ce cycles with inp_valid=00 -> err=1 at the 16th edge, FSM back to IDLE.
- INC_MUL, opa=3, opb=4, inp_valid=11 -> res=20 at the 2nd edge. Without ALU_MUL_EN -> err=1 at the 1st edge.
- ROL_A_B, opa=8'h81, opb=8'h10 -> err=1, res=9'h081. Assert rst during MUL -> all outputs 0 immediately.
